// File: rtl/mc_alu.sv
// mc_alu: multi-cycle EX-stage ALU with a valid/ready operand handshake.
// It adds shift-add multiply, restoring divide, signed compare and
// arithmetic shift to the 4-bit control set of the single-cycle ALU.
// Ports:
//   clk, rst_n          clock and synchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready = !busy
//   a, b, control       operands and operation select
//   result, hi          low result / quotient, and high product / remainder
//   zero, div_by_zero   flags, registered with result
//   busy, done          busy while iterating; done pulses for one cycle
// Define MC_ALU_SIGNED_MULDIV_EN to add signed mult (0011) and div (0101).
module mc_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MULT  = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_SRA   = 4'b1011;
    localparam logic [3:0] OP_SRL   = 4'b1100;
    localparam logic [3:0] OP_SLL   = 4'b1101;
    localparam logic [3:0] OP_XOR   = 4'b1110;

`ifdef MC_ALU_SIGNED_MULDIV_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    // acc: product high / partial remainder; lo: multiplier / dividend-quotient
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    // neg_lo: negate product or quotient; neg_hi: negate remainder
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic             is_mul, is_div, is_sgn;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi, mul_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_rem, div_quo;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] v,
        input logic             s
    );
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    assign shamt = b[SHW-1:0];

    always_comb begin
        alu_res = a + b;
        case (control)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_SUB:  alu_res = a - b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SRL:  alu_res = a >> shamt;
            OP_SLL:  alu_res = a << shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            default: alu_res = a + b;
        endcase
    end

    assign is_sgn = SIGNED_EN && (control == OP_MULT || control == OP_DIV);
    assign is_mul = (control == OP_MULTU) || (SIGNED_EN && control == OP_MULT);
    assign is_div = (control == OP_DIVU) || (SIGNED_EN && control == OP_DIV);

    // One shift-add step: add multiplicand when multiplier LSB set, shift right.
    assign mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign mul_hi   = mul_sum[WIDTH:1];
    assign mul_lo   = {mul_sum[0], lo_q[WIDTH-1:1]};
    assign prod_raw = {mul_hi, mul_lo};
    assign prod_fix = neg_lo_q ? -prod_raw : prod_raw;

    // One restoring step: shift in next dividend bit, subtract if it fits.
    assign div_shift = {acc_q, lo_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opd_q;
    assign div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_quo   = {lo_q[WIDTH-2:0], div_ge};
    assign quo_fix   = neg_lo_q ? -div_quo : div_quo;
    assign rem_fix   = neg_hi_q ? -div_rem : div_rem;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        result_d = result_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dbz_d = 1'b0;
                    if (is_mul) begin
                        acc_d    = '0;
                        lo_d     = mag(b, is_sgn);
                        opd_d    = mag(a, is_sgn);
                        neg_lo_d = is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d = 1'b0;
                        cnt_d    = CNT_INIT;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else if (is_div && b == '0) begin
                        result_d = '1;
                        hi_d     = a;
                        zero_d   = 1'b0;
                        dbz_d    = 1'b1;
                        done_d   = 1'b1;
                    end else if (is_div) begin
                        acc_d    = '0;
                        lo_d     = mag(a, is_sgn);
                        opd_d    = mag(b, is_sgn);
                        neg_lo_d = is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_hi_d = is_sgn && a[WIDTH-1];
                        cnt_d    = CNT_INIT;
                        busy_d   = 1'b1;
                        state_d  = S_DIV;
                    end else begin
                        result_d = alu_res;
                        hi_d     = '0;
                        zero_d   = (alu_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_hi;
                lo_d  = mul_lo;
                if (cnt_q == '0) begin
                    result_d = prod_fix[WIDTH-1:0];
                    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
                    zero_d   = (prod_fix[WIDTH-1:0] == '0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                acc_d = div_rem;
                lo_d  = div_quo;
                if (cnt_q == '0) begin
                    result_d = quo_fix;
                    hi_d     = rem_fix;
                    zero_d   = (quo_fix == '0);
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            result_q <= '0;
            hi_q     <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            result_q <= result_d;
            hi_q     <= hi_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign in_ready    = !busy_q;
    assign result      = result_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: directed self-checking bench for mc_alu.
// Inputs change and outputs are sampled on negedge.
module tb_mc_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic [31:0] result;
  logic [31:0] hi;
  logic        zero;
  logic        div_by_zero;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  mc_alu #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .control(control),
    .result(result),
    .hi(hi),
    .zero(zero),
    .div_by_zero(div_by_zero),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(
    input logic [31:0] ia,
    input logic [31:0] ib,
    input logic [3:0]  ic
  );
    a = ia;
    b = ib;
    control = ic;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(
    output int lat,
    output int bcnt
  );
    lat = 1;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    control = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({result, hi, zero, div_by_zero,
         busy, done, in_ready}
        !== {64'h0, 5'b00001}) begin
      failures++;
      $display("FAIL reset_state r=%h hi=%h z=%b",
               result, hi, zero);
    end
    rst_n = 1'b1;
    issue(32'hFFFF_FFFF, 32'h3, 4'b1000);
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_busy busy=%b", busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, result, hi}
        !== {2'b00, 64'h0}) begin
      failures++;
      $display("FAIL reset_abort busy=%b done=%b",
               busy, done);
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_no_done act=%0d", seen);
    end
  endtask

  task automatic test_single();
    issue(32'd7, 32'd7, 4'b0110);
    checks++;
    if ({result, hi, zero, done, busy}
        !== {64'h0, 3'b110}) begin
      failures++;
      $display("FAIL sub_zero r=%h z=%b d=%b b=%b",
               result, zero, done, busy);
    end
    issue(32'h8000_0000, 32'd1, 4'b1011);
    checks++;
    if (result !== 32'hC000_0000 ||
        zero !== 1'b0) begin
      failures++;
      $display("FAIL sra r=%h z=%b", result, zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 ||
        result !== 32'hC000_0000) begin
      failures++;
      $display("FAIL single_pulse d=%b r=%h",
               done, result);
    end
  endtask

  task automatic test_compare();
    issue(32'hFFFF_FFFF, 32'd1, 4'b0111);
    checks++;
    if (result !== 32'd0) begin
      failures++;
      $display("FAIL sltu r=%h want 0", result);
    end
    issue(32'hFFFF_FFFF, 32'd1, 4'b1010);
    checks++;
    if (result !== 32'd1) begin
      failures++;
      $display("FAIL slt r=%h want 1", result);
    end
  endtask

  task automatic test_multiply();
    int lat;
    int bc;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000);
    lat = 1;
    bc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      in_valid = (lat == 5 || lat == 10);
      a = 32'd1;
      b = 32'd1;
      control = 4'b0010;
      @(negedge clk);
      lat++;
      if (busy === 1'b1) bc++;
    end
    in_valid = 1'b0;
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL mul_latency got=%0d", lat);
    end
    checks++;
    if (bc != 32) begin
      failures++;
      $display("FAIL mul_busy got=%0d", bc);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFE ||
        result !== 32'h1 ||
        zero !== 1'b0) begin
      failures++;
      $display("FAIL mul_value hi=%h lo=%h z=%b",
               hi, result, zero);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 ||
        result !== 32'h1) begin
      failures++;
      $display("FAIL mul_after d=%b b=%b r=%h",
               done, busy, result);
    end
  endtask

  task automatic test_divide();
    int lat;
    int bc;
    issue(32'd100, 32'd7, 4'b1001);
    wait_done(lat, bc);
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL div_latency got=%0d", lat);
    end
    checks++;
    if (result !== 32'd14 || hi !== 32'd2 ||
        div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL div_value q=%h r=%h dbz=%b",
               result, hi, div_by_zero);
    end
    issue(32'd5, 32'd0, 4'b1001);
    checks++;
    if ({done, busy, div_by_zero, zero}
        !== 4'b1010 ||
        result !== 32'hFFFF_FFFF ||
        hi !== 32'd5) begin
      failures++;
      $display("FAIL div_zero d=%b dbz=%b q=%h r=%h",
               done, div_by_zero, result, hi);
    end
    @(negedge clk);
    checks++;
    if (div_by_zero !== 1'b1 ||
        done !== 1'b0) begin
      failures++;
      $display("FAIL dbz_hold dbz=%b d=%b",
               div_by_zero, done);
    end
    issue(32'd1, 32'd1, 4'b0010);
    checks++;
    if (div_by_zero !== 1'b0 ||
        result !== 32'd2) begin
      failures++;
      $display("FAIL dbz_clear dbz=%b r=%h",
               div_by_zero, result);
    end
  endtask

  task automatic test_signed();
    int lat;
    int bc;
    issue(32'hFFFF_FFF9, 32'd2, 4'b0101);
`ifdef MC_ALU_SIGNED_MULDIV_EN
    wait_done(lat, bc);
    checks++;
    if (lat != 33) begin
      failures++;
      $display("FAIL sdiv_latency got=%0d", lat);
    end
    checks++;
    if (result !== 32'hFFFF_FFFD ||
        hi !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL sdiv_value q=%h r=%h",
               result, hi);
    end
    issue(32'hFFFF_FFFD, 32'd5, 4'b0011);
    wait_done(lat, bc);
    checks++;
    if (lat != 33 ||
        result !== 32'hFFFF_FFF1 ||
        hi !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL smul lat=%0d lo=%h hi=%h",
               lat, result, hi);
    end
`else
    bc = 0;
    lat = (done === 1'b1) ? 1 : 0;
    checks++;
    if (lat != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sdiv_off_lat d=%b b=%b",
               done, busy);
    end
    checks++;
    if (result !== 32'hFFFF_FFFB ||
        hi !== 32'h0) begin
      failures++;
      $display("FAIL sdiv_off_add r=%h hi=%h",
               result, hi);
    end
    issue(32'hFFFF_FFFD, 32'd5, 4'b0011);
    checks++;
    if (done !== 1'b1 || result !== 32'd2 ||
        bc != 0) begin
      failures++;
      $display("FAIL smul_off_add d=%b r=%h",
               done, result);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [8] = '{
      32'd5, 32'hF0, 32'h0, 32'hAA, 32'hF0,
      32'h1, 32'h8000_0000, 32'd2};
    logic [31:0] vb [8] = '{
      32'd3, 32'h0F, 32'h0, 32'hFF, 32'h3C,
      32'h104, 32'h21, 32'd3};
    logic [3:0]  vc [8] = '{
      4'b0010, 4'b0001, 4'b0100, 4'b1110,
      4'b0000, 4'b1101, 4'b1100, 4'b1111};
    logic [31:0] vr [8] = '{
      32'd8, 32'hFF, 32'hFFFF_FFFF, 32'h55,
      32'h30, 32'h10, 32'h4000_0000, 32'd5};
    int lat;
    int bc;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = va[i];
      b = vb[i];
      control = vc[i];
      @(negedge clk);
      checks++;
      if (result !== vr[i] || done !== 1'b1 ||
          busy !== 1'b0) begin
        failures++;
        $display("FAIL b2b_%0d r=%h d=%b b=%b",
                 i, result, done, busy);
      end
    end
    in_valid = 1'b0;
    issue(32'd9, 32'd3, 4'b1001);
    wait_done(lat, bc);
    checks++;
    if (lat != 33 || result !== 32'd3 ||
        hi !== 32'd0) begin
      failures++;
      $display("FAIL b2b_div lat=%0d q=%h r=%h",
               lat, result, hi);
    end
    issue(32'd2, 32'd2, 4'b0010);
    checks++;
    if (done !== 1'b1 || result !== 32'd4 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_after d=%b r=%h b=%b",
               done, result, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_compare();
    test_multiply();
    test_divide();
    test_signed();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
